// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequentially from imem and buffers {pc, instr} for the datapath.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [4:0]  count
);

   localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] DEPTH_C = 5'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [4:0]    count_q, count_d;
   logic [31:0]   instr_q [DEPTH];
   logic [31:0]   instr_d [DEPTH];
   logic [31:0]   pc_q    [DEPTH];
   logic [31:0]   pc_d    [DEPTH];
   logic          out_valid_q, out_valid_d;
   logic [31:0]   out_instr_q, out_instr_d;
   logic [31:0]   out_pc_q, out_pc_d;

   logic          q_pop_s, pop_s, push_s, store_s, bypass_take_s;
   logic [PW-1:0] head_sel_s;
   logic          unused_s;

   assign unused_s = ^redirect_pc[1:0];

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass_s;
   assign bypass_s      = (count_q == 5'd0) && !reset && !redirect_valid;
   assign bypass_take_s = bypass_s && out_ready;
   assign out_valid     = bypass_s ? 1'b1      : out_valid_q;
   assign out_instr     = bypass_s ? imem_data : out_instr_q;
   assign out_pc        = bypass_s ? fetch_pc_q : out_pc_q;
`else
   assign bypass_take_s = 1'b0;
   assign out_valid     = out_valid_q;
   assign out_instr     = out_instr_q;
   assign out_pc        = out_pc_q;
`endif

   assign imem_addr = fetch_pc_q;
   assign count     = count_q;

   // A bypassed word counts as both pushed and popped, so it never touches storage.
   assign q_pop_s = out_valid_q && out_ready;
   assign pop_s   = q_pop_s || bypass_take_s;
   assign push_s  = !redirect_valid && ((count_q < DEPTH_C) || pop_s);
   assign store_s = push_s && !bypass_take_s;

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      instr_d     = instr_q;
      pc_d        = pc_q;
      out_valid_d = 1'b0;
      out_instr_d = 32'h0000_0000;
      out_pc_d    = 32'h0000_0000;
      head_sel_s  = q_pop_s ? head_q + PW'(1) : head_q;

      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         head_d     = '0;
         tail_d     = '0;
         count_d    = 5'd0;
      end else begin
         if (store_s) begin
            instr_d[tail_q] = imem_data;
            pc_d[tail_q]    = fetch_pc_q;
            tail_d          = tail_q + PW'(1);
         end else begin
            tail_d = tail_q;
         end
         if (q_pop_s) begin
            head_d = head_q + PW'(1);
         end else begin
            head_d = head_q;
         end
         if (push_s) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
         count_d = count_q + {4'b0000, store_s} - {4'b0000, q_pop_s};
      end

      // Next head is either already stored or the word being written this cycle.
      if (count_d != 5'd0) begin
         out_valid_d = 1'b1;
         if (store_s && (tail_q == head_sel_s)) begin
            out_instr_d = imem_data;
            out_pc_d    = fetch_pc_q;
         end else begin
            out_instr_d = instr_q[head_sel_s];
            out_pc_d    = pc_q[head_sel_s];
         end
      end else begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q  <= RESET_PC;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= 5'd0;
         out_valid_q <= 1'b0;
         out_instr_q <= 32'h0000_0000;
         out_pc_q    <= 32'h0000_0000;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed stimulus pushes expected {pc, instr}; a monitor checks each handshake.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [4:0]  count;

   int n_checks = 0;
   int n_fail = 0;
   int hs = 0;
   logic [63:0] sb[$];

   fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .count(count)
   );

   always #5 clk = ~clk;

   // Memory model: the word at address 4*i is i.
   assign imem_data = {2'b00, imem_addr[31:2]};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_pc(input logic [31:0] pc);
      sb.push_back({pc, 2'b00, pc[31:2]});
   endtask

   task automatic wait_hs(input int target, input int budget);
      int g = 0;
      while (hs < target && g < budget) begin
         step(1);
         g++;
      end
      chk("handshake_budget", 32'(hs), 32'(target));
   endtask

   // Monitor: every accepted head entry must match the next expected one.
   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_pop_pc", out_pc, 32'hFFFF_FFFF);
            end else begin
               logic [63:0] e;
               e = sb.pop_front();
               chk("pop_pc", out_pc, e[63:32]);
               chk("pop_instr", out_instr, e[31:0]);
            end
            hs++;
         end else if (!out_valid) begin
            chk("idle_pc_zero", out_pc, 32'h0);
            chk("idle_instr_zero", out_instr, 32'h0);
         end
      end
   end

   initial begin
      int first;
      int gaps;
      int cyc;
      int target;

      // Reset and fill
      reset = 1'b1;
      step(1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_pc", out_pc, 32'h0);
      reset = 1'b0;
      step(4);
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_addr", imem_addr, 32'h10);
      chk("fill_head_pc", out_pc, 32'h0);
      chk("fill_head_instr", out_instr, 32'h0);
      chk("fill_valid", 32'(out_valid), 32'd1);
      step(2);
      chk("full_hold_addr", imem_addr, 32'h10);
      chk("full_hold_count", 32'(count), 32'd4);

      // Full with simultaneous push and pop
      expect_pc(32'h0);
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      chk("pp_count", 32'(count), 32'd4);
      chk("pp_head_pc", out_pc, 32'h4);
      chk("pp_head_instr", out_instr, 32'h1);
      chk("pp_addr", imem_addr, 32'h14);
      for (int i = 1; i <= 4; i++) expect_pc(32'(i * 4));
      target = hs + 4;
      out_ready = 1'b1;
      wait_hs(target, 20);
      out_ready = 1'b0;
      chk("drain_count", 32'(count), 32'd4);

      // Mid-stream reset, then streaming
      reset = 1'b1;
      step(1);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_addr", imem_addr, 32'h0);
      for (int i = 0; i < 10; i++) expect_pc(32'(i * 4));
      target = hs + 10;
      reset = 1'b0;
      out_ready = 1'b1;
      first = 0;
      gaps = 0;
      cyc = 1;
      while (hs < target && cyc < 40) begin
         if (out_valid) begin
            if (first == 0) first = cyc;
         end else if (first != 0) begin
            gaps++;
         end
         step(1);
         cyc++;
      end
      out_ready = 1'b0;
      chk("stream_handshakes", 32'(hs), 32'(target));
      chk("stream_gaps", 32'(gaps), 32'd0);
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("stream_first_valid", 32'(first), 32'd1);
`else
      chk("stream_first_valid", 32'(first), 32'd2);
`endif

      // Redirect coinciding with a pop
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(3);
      chk("redir_pre_count", 32'(count), 32'd3);
      expect_pc(32'h0);
      target = hs + 1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      out_ready = 1'b1;
      step(1);
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      chk("redir_pop_taken", 32'(hs), 32'(target));
      chk("redir_count", 32'(count), 32'd0);
      chk("redir_addr", imem_addr, 32'h100);
`ifndef FETCH_QUEUE_BYPASS_EN
      chk("redir_valid", 32'(out_valid), 32'd0);
`endif
      step(1);
      chk("redir_next_count", 32'(count), 32'd1);
      chk("redir_next_pc", out_pc, 32'h100);
      chk("redir_next_instr", out_instr, 32'h40);

      // Address wrap-around
      expect_pc(32'h100);
      expect_pc(32'hFFFF_FFF8);
      expect_pc(32'hFFFF_FFFC);
      expect_pc(32'h0000_0000);
      expect_pc(32'h0000_0004);
      target = hs + 5;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      out_ready = 1'b1;
      step(1);
      redirect_valid = 1'b0;
      wait_hs(target, 20);
      out_ready = 1'b0;

`ifdef FETCH_QUEUE_BYPASS_EN
      // Same-cycle bypass of an empty queue
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      expect_pc(32'h0);
      out_ready = 1'b1;
      #1;
      chk("byp_valid", 32'(out_valid), 32'd1);
      chk("byp_instr", out_instr, 32'h0);
      chk("byp_count", 32'(count), 32'd0);
      step(1);
      out_ready = 1'b0;
      chk("byp_count_after", 32'(count), 32'd0);
`endif

      step(2);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
